// File: rtl/ayatsuki_dmem.sv
// ayatsuki_dmem: big-endian byte-addressed data RAM plus MMIO window for ayatsuki_core
//   clk, rst_n (async active-low)      clock and reset
//   mem_enable_i / mem_w_enable_i /     access qualifiers from the core
//   mem_r_enable_i
//   mem_w_addr_i, mem_data_i           store byte address and big-endian data
//   mem_r_addr_i, mem_data_o           load byte address and combinational data
//   halt_o, halt_code_o                sticky TOHOST halt flag and latched code
//   err_o, err_addr_o                  sticky out-of-range flag and first address
//   Define DMEM_ERR_EN to build the out-of-range error capture; otherwise err_* are 0.
//   MMIO word offsets: 0x00 CYCLE_LO, 0x04 CYCLE_HI, 0x08 STORES, 0x0C SCRATCH, 0x10 TOHOST.
module ayatsuki_dmem #(
    parameter int          DEPTH_BYTES = 2048,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_enable_i,
    input  logic        mem_w_enable_i,
    input  logic        mem_r_enable_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic [31:0] mem_r_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        halt_o,
    output logic [31:0] halt_code_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);
    localparam int          AW       = $clog2(DEPTH_BYTES);
    localparam logic [31:0] RAM_LAST = 32'(DEPTH_BYTES - 4);
    typedef enum logic {RUN, HALTED} state_t;
    state_t      state;
    logic [7:0]  mem [DEPTH_BYTES];
    logic [63:0] cycle;
    logic [31:0] stores;
    logic [31:0] scratch;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic rd, wr, rd_ram, wr_ram, rd_mmio, wr_mmio;
    assign rd      = mem_enable_i && mem_r_enable_i;
    assign wr      = mem_enable_i && mem_w_enable_i;
    assign rd_ram  = rd && (mem_r_addr_i <= RAM_LAST);
    assign wr_ram  = wr && (mem_w_addr_i <= RAM_LAST);
    // MMIO hits require the 32-byte window and word alignment
    assign rd_mmio = rd && (mem_r_addr_i[31:5] == MMIO_BASE[31:5]) && (mem_r_addr_i[1:0] == 2'd0);
    assign wr_mmio = wr && (mem_w_addr_i[31:5] == MMIO_BASE[31:5]) && (mem_w_addr_i[1:0] == 2'd0);
    assign ra      = mem_r_addr_i[AW-1:0];
    assign wa      = mem_w_addr_i[AW-1:0];
    assign halt_o  = (state == HALTED);
    assign ram_rdata = {mem[ra], mem[ra + AW'(1)], mem[ra + AW'(2)], mem[ra + AW'(3)]};
    always_comb begin
        mmio_rdata = '0;
        case (mem_r_addr_i[4:2])
            3'd0:    mmio_rdata = cycle[31:0];
            3'd1:    mmio_rdata = cycle[63:32];
            3'd2:    mmio_rdata = stores;
            3'd3:    mmio_rdata = scratch;
            3'd4:    mmio_rdata = halt_code_o;
            default: mmio_rdata = '0;
        endcase
    end
    assign mem_data_o = rd_ram ? ram_rdata : rd_mmio ? mmio_rdata : '0;
    // RAM is never cleared; a store presented while reset is asserted is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n && wr_ram) begin
            mem[wa]          <= mem_data_i[31:24];
            mem[wa + AW'(1)] <= mem_data_i[23:16];
            mem[wa + AW'(2)] <= mem_data_i[15:8];
            mem[wa + AW'(3)] <= mem_data_i[7:0];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            halt_code_o <= '0;
            cycle       <= '0;
            stores      <= '0;
            scratch     <= '0;
        end else begin
            if (state == RUN) cycle <= cycle + 64'd1;
            if (wr_ram) stores <= stores + 32'd1;
            if (wr_mmio && mem_w_addr_i[4:2] == 3'd3) scratch <= mem_data_i;
            if (wr_mmio && mem_w_addr_i[4:2] == 3'd4 && state == RUN) begin
                state       <= HALTED;
                halt_code_o <= mem_data_i;
            end
        end
    end
`ifdef DMEM_ERR_EN
    logic rd_bad, wr_bad;
    assign rd_bad = rd && !rd_ram && !rd_mmio;
    assign wr_bad = wr && !wr_ram && !wr_mmio;
    // first fault wins; a simultaneous store fault takes priority over the load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (!err_o && (rd_bad || wr_bad)) begin
            err_o      <= 1'b1;
            err_addr_o <= wr_bad ? mem_w_addr_i : mem_r_addr_i;
        end
    end
`else
    assign err_o      = 1'b0;
    assign err_addr_o = '0;
`endif
endmodule

// File: tb/tb_ayatsuki_dmem.sv
// tb_ayatsuki_dmem: randomized self-checking bench for ayatsuki_dmem against a behavioural model
module tb_ayatsuki_dmem;
    localparam int          DEPTH = 2048;
    localparam logic [31:0] MB    = 32'h0000_F000;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, we, re;
    logic [31:0] waddr, raddr, wdata;
    logic [31:0] mem_data_o;
    logic        halt_o;
    logic [31:0] halt_code_o;
    logic        err_o;
    logic [31:0] err_addr_o;
    int passed = 0;
    int total  = 0;
    ayatsuki_dmem #(.DEPTH_BYTES(DEPTH), .MMIO_BASE(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_enable_i(en), .mem_w_enable_i(we), .mem_r_enable_i(re),
        .mem_w_addr_i(waddr), .mem_r_addr_i(raddr), .mem_data_i(wdata),
        .mem_data_o(mem_data_o), .halt_o(halt_o), .halt_code_o(halt_code_o),
        .err_o(err_o), .err_addr_o(err_addr_o)
    );
    always #5 clk = ~clk;
    logic [7:0]  m_ram [DEPTH];
    logic [63:0] m_cyc;
    logic [31:0] m_stores, m_scratch, m_code, m_eaddr;
    bit          m_halt, m_err, m_rd, m_wr;
    function automatic bit in_ram(logic [31:0] a);
        return longint'(a) + 3 < longint'(DEPTH);
    endfunction
    function automatic bit in_mmio(logic [31:0] a);
        return a >= MB && a < MB + 32 && a % 4 == 0;
    endfunction
    function automatic bit bad(logic [31:0] a);
        return !in_ram(a) && !in_mmio(a);
    endfunction
    function automatic logic [31:0] exp_rd();
        int a;
        if (!(en && re)) return 32'h0;
        a = int'(raddr);
        if (in_ram(raddr)) return {m_ram[a], m_ram[a+1], m_ram[a+2], m_ram[a+3]};
        if (in_mmio(raddr)) begin
            case (int'((raddr - MB) / 4))
                0:       return m_cyc[31:0];
                1:       return m_cyc[63:32];
                2:       return m_stores;
                3:       return m_scratch;
                4:       return m_code;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_stores = 0; m_scratch = 0; m_code = 0; m_halt = 0;
            m_err = 0; m_eaddr = 0;
        end else begin
            m_wr = en && we;
            m_rd = en && re;
`ifdef DMEM_ERR_EN
            if (!m_err && ((m_wr && bad(waddr)) || (m_rd && bad(raddr)))) begin
                m_err = 1;
                m_eaddr = (m_wr && bad(waddr)) ? waddr : raddr;
            end
`endif
            if (!m_halt) m_cyc += 64'd1;
            if (m_wr && in_ram(waddr)) begin
                for (int k = 0; k < 4; k++) m_ram[int'(waddr) + k] = wdata[31 - 8*k -: 8];
                m_stores += 32'd1;
            end else if (m_wr && in_mmio(waddr)) begin
                if (waddr == MB + 12) m_scratch = wdata;
                if (waddr == MB + 16 && !m_halt) begin
                    m_halt = 1;
                    m_code = wdata;
                end
            end
        end
    end
    task automatic check(string n, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", n, got, exp);
        else passed++;
    endtask
    always @(negedge clk) begin
        check("data", mem_data_o, exp_rd());
        check("halt", {31'b0, halt_o}, {31'b0, m_halt});
        check("halt_code", halt_code_o, m_code);
        check("err", {31'b0, err_o}, {31'b0, m_err});
        check("err_addr", err_addr_o, m_eaddr);
    end
    task automatic drv(bit e, bit w, bit r, logic [31:0] wa, logic [31:0] ra, logic [31:0] d);
        en = e; we = w; re = r; waddr = wa; raddr = ra; wdata = d;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'($urandom_range(0, DEPTH + 3));
            2:       return MB + 32'($urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction
    initial begin
        logic [31:0] s0, c;
        logic [31:0] wa;
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        step(); step();
        check("rst_halt", {31'b0, halt_o}, 32'h0);
        check("rst_code", halt_code_o, 32'h0);
        check("rst_err", {31'b0, err_o}, 32'h0);
        check("rst_eaddr", err_addr_o, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH / 4; i++) begin
            drv(1, 1, 0, 32'(i * 4), 0, $urandom);
            step();
        end
        drv(1, 0, 1, 0, MB, 0);
        rst_n = 1'b0;
        #1;
        check("rst_cycle_lo", mem_data_o, 32'h0);
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("cycle_lo_10", mem_data_o, 32'd10);
`ifdef DMEM_ERR_EN
        drv(1, 0, 1, 0, 32'h900, 0);
        #1;
        check("err_load_data", mem_data_o, 32'h0);
        step();
        check("err_flag", {31'b0, err_o}, 32'h1);
        check("err_first", err_addr_o, 32'h900);
        drv(1, 0, 1, 0, 32'hA00, 0);
        step();
        check("err_sticky", err_addr_o, 32'h900);
`endif
        repeat (1500) begin
            wa = rnd_addr();
            if (wa == MB + 16) wa = MB + 12;
            drv(1'($urandom), 1'($urandom), 1'($urandom), wa, rnd_addr(), $urandom);
            step();
        end
        drv(1, 1, 0, 32'h10, 0, 32'hDEADBEEF);
        step();
        drv(1, 0, 1, 0, 32'h10, 0);
        #1;
        check("load_10", mem_data_o, 32'hDEADBEEF);
        drv(1, 0, 1, 0, 32'h11, 0);
        #1;
        check("load_11", mem_data_o, {24'hADBEEF, m_ram[20]});
        drv(1, 0, 1, 0, MB + 8, 0);
        #1;
        s0 = m_stores;
        check("stores_now", mem_data_o, s0);
        drv(1, 1, 0, 32'h7FD, 0, 32'h11223344);
        step();
        drv(1, 0, 1, 0, 32'h7FD, 0);
        #1;
        check("load_7fd", mem_data_o, 32'h0);
        drv(1, 0, 1, 0, MB + 8, 0);
        #1;
        check("stores_drop", mem_data_o, s0);
        drv(1, 1, 0, 32'h7FC, 0, 32'h11223344);
        step();
        drv(1, 0, 1, 0, MB + 8, 0);
        #1;
        check("stores_inc", mem_data_o, s0 + 32'd1);
        drv(1, 1, 0, 32'h20, 0, 32'hA5A5A5A5);
        step();
        drv(1, 1, 1, 32'h20, 32'h20, 32'h5A5A5A5A);
        #1;
        check("war_old", mem_data_o, 32'hA5A5A5A5);
        step();
        drv(1, 0, 1, 0, 32'h20, 0);
        #1;
        check("war_new", mem_data_o, 32'h5A5A5A5A);
        drv(1, 1, 1, MB + 16, MB, 32'h1);
        #1;
        c = m_cyc[31:0];
        step();
        check("halt_set", {31'b0, halt_o}, 32'h1);
        check("halt_code1", halt_code_o, 32'h1);
        drv(1, 0, 1, 0, MB, 0);
        #1;
        check("cyc_at_halt", mem_data_o, c + 32'd1);
        repeat (3) step();
        check("cyc_frozen", mem_data_o, c + 32'd1);
        drv(1, 1, 0, MB + 16, 0, 32'h2);
        step();
        check("halt_code_keep", halt_code_o, 32'h1);
        drv(1, 1, 0, MB + 12, 0, 32'h1234);
        step();
        drv(1, 0, 1, 0, MB + 12, 0);
        #1;
        check("scratch_halted", mem_data_o, 32'h1234);
        drv(1, 1, 1, 32'h10, MB + 12, 32'hCAFEF00D);
        rst_n = 1'b0;
        #1;
        check("rst_scratch", mem_data_o, 32'h0);
        check("rst_halt2", {31'b0, halt_o}, 32'h0);
        check("rst_code2", halt_code_o, 32'h0);
        step();
        drv(1, 0, 1, 0, MB + 8, 0);
        #1;
        check("rst_stores", mem_data_o, 32'h0);
        rst_n = 1'b1;
        drv(1, 0, 1, 0, 32'h10, 0);
        #1;
        check("ram_kept", mem_data_o, 32'hDEADBEEF);
        step();
        drv(0, 0, 0, 0, 0, 0);
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ayatsuki_dmem.md
Name: ayatsuki_dmem

Overview:
Synthesizable data-memory responder for the memory port of ayatsuki_core: the core is the initiator and this block answers its loads and stores. It contains a byte-addressed big-endian RAM, plus a small memory-mapped I/O window holding a cycle counter, a store counter, a scratch register and a tohost halt register. It replaces the behavioural data RAM used in simulation, so the same block serves both simulation and FPGA builds.

Parameters:
DEPTH_BYTES, 2048, RAM size in bytes; must be a power of two and ≥ 4
MMIO_BASE, 32'h0000_F000, base byte address of the 32-byte MMIO window; must be 32-byte aligned and lie outside [0, DEPTH_BYTES)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
mem_enable_i  input  1  global access qualifier from the core
mem_w_enable_i  input  1  store request; valid only with mem_enable_i
mem_r_enable_i  input  1  load request; valid only with mem_enable_i
mem_w_addr_i  input  32  store byte address
mem_r_addr_i  input  32  load byte address
mem_data_i  input  32  store data, big-endian: [31:24] goes to the lowest address
mem_data_o  output  32  load data, combinational
halt_o  output  1  sticky flag, set by a store to TOHOST
halt_code_o  output  32  value latched by the first TOHOST store
err_o  output  1  sticky out-of-range flag (see Optional Feature)
err_addr_o  output  32  first faulting address (see Optional Feature)

Behaviour:
- Reset: clock and reset are fixed as one clock `clk` with an asynchronous active-low reset `rst_n`. While reset is asserted:
  - halt_o=0, halt_code_o=0, err_o=0, err_addr_o=0.
  - Cycle counter, store counter and SCRATCH are all 0.
  - RAM contents are not reset.
  - mem_data_o remains combinational and follows the rules below.
- Load (rd = mem_enable_i & mem_r_enable_i):
  - Zero latency: mem_data_o = {M[a], M[a+1], M[a+2], M[a+3]} with a = mem_r_addr_i.
  - Unaligned addresses are legal and handled byte-wise.
  - Valid RAM access requires a ≤ DEPTH_BYTES-4; an address outside RAM and outside the MMIO window returns 32'h0.
  - When rd=0, mem_data_o=0.
- Store (wr = mem_enable_i & mem_w_enable_i):
  - Writes 4 bytes at the rising edge, at mem_w_addr_i ≤ DEPTH_BYTES-4. Unaligned stores are legal.
  - An out-of-range store is dropped.
- Read and write in the same cycle to overlapping bytes: the load returns the old data (write-after-read); the new data is visible from the next cycle.
- MMIO window: the window is [MMIO_BASE, MMIO_BASE+31]. Word-aligned offsets only; unaligned MMIO accesses read 0 and stores to them are dropped.
  - 0x00 CYCLE_LO (RO): low 32 bits of a 64-bit cycle counter.
  - 0x04 CYCLE_HI (RO): high 32 bits of the cycle counter.
  - 0x08 STORES (RO): number of accepted RAM stores.
  - 0x0C SCRATCH (RW).
  - 0x10 TOHOST (RW): reads return halt_code_o.
  - 0x14–0x1C: reserved; read 0, stores dropped.
  - Stores to RO registers are dropped.
- Cycle counter:
  - Increments every cycle after reset deassertion while halt_o=0; it freezes while halt_o=1.
  - Wraps from 2^64-1 to 0.
  - A read returns the pre-edge value.
- Store counter:
  - Increments by 1 on each accepted RAM store, and never on MMIO stores.
  - Wraps from 32'hFFFF_FFFF to 0.
- Halt state machine, RUN → HALTED:
  - In RUN, a store to TOHOST latches halt_code_o=mem_data_i and sets halt_o=1 at the same edge.
  - In HALTED, further TOHOST stores are ignored; RAM, SCRATCH and STORES remain writable.
  - Only rst_n returns the machine to RUN.
- Reset asserted mid-operation: a store presented in the same cycle is discarded and all registers clear immediately.

Optional Feature:
- Macro: DMEM_ERR_EN.
- With the macro defined:
  - An access is out of range when rd or wr is active and the address is outside the RAM, outside the MMIO window, or unaligned inside the MMIO window.
  - On the first out-of-range access, err_o becomes 1 at the next edge and err_addr_o captures the faulting address.
  - If a load and a store fault in the same cycle, the store address is captured.
  - The flag and address are sticky until reset.
- Without the macro: err_o and err_addr_o are tied to 0 and no error logic is generated.

Test Plan:
- Store 32'hDEADBEEF at address 0x10, then load 0x10 → 32'hDEADBEEF; byte 0x10=8'hDE, byte 0x13=8'hEF (checked via a load at 0x11 returning 32'hADBEEFxx, where xx is the existing content of 0x14).
- Unaligned store 32'h11223344 at 0x7FD (DEPTH 2048) → dropped, a load at 0x7FD returns 0 and STORES is unchanged. A store at 0x7FC is accepted and STORES increments by 1.
- Same-cycle load and store at 0x20 with old value 32'hA5A5A5A5 and new value 32'h5A5A5A5A → the load returns 32'hA5A5A5A5 that cycle and 32'h5A5A5A5A the next cycle.
- Release reset, run 10 cycles, then read CYCLE_LO → 10 (±0, exact edge count). Store 32'h1 to TOHOST → halt_o=1 and halt_code_o=1, CYCLE_LO frozen. A second TOHOST store of 32'h2 leaves halt_code_o=1.
- Assert rst_n=0 while halted with SCRATCH=32'h1234 → halt_o=0, SCRATCH=0 and the counters clear immediately without a clock edge; RAM data at 0x10 is preserved.
- With DMEM_ERR_EN: load 0x900 → mem_data_o=0, then err_o=1 and err_addr_o=32'h900. A later fault at 0xA00 leaves err_addr_o=32'h900.
